// File: rtl/note_tone_generator_if.sv
// Note-code input and tone output bundle between the music memory read port and the tone generator.
interface note_tone_generator_if #(
  parameter int DATA_WIDTH = 10
);
  logic                  enable;
  logic                  note_valid;
  logic [DATA_WIDTH-1:0] note_code;
  logic                  tone_out;
  logic                  playing;
  logic                  code_err;

  modport master (
    output enable, note_valid, note_code,
    input  tone_out, playing, code_err
  );

  modport slave (
    input  enable, note_valid, note_code,
    output tone_out, playing, code_err
  );
endinterface

// File: rtl/note_tone_generator.sv
// Square-wave buzzer tone from a stream of 10-bit note codes via a half-period lookup and counter.
// Optional macro TONE_SYNC_CHANGE_EN defers note-to-note changes to the next toggle point.
module note_tone_generator #(
  parameter int CNT_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  note_tone_generator_if.slave  bus
);

  logic [9:0]           r_cur_code;
  logic [CNT_WIDTH-1:0] r_half_per;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_tone;
  logic                 r_playing;
  logic                 r_code_err;

  logic [9:0]           w_eff_code;
  logic                 w_eff_rest;
  logic                 w_eff_invalid;
  logic                 w_eff_note;
  logic                 w_change;
  logic                 w_toggle;
  logic                 w_load;
  logic [CNT_WIDTH-1:0] w_next_hp;

  function automatic logic [CNT_WIDTH-1:0] f_half_per(input logic [9:0] code);
    logic [CNT_WIDTH-1:0] base;
    base = '0;
    case (code[8:2])
      7'b0000001: base = CNT_WIDTH'(191110);
      7'b0000010: base = CNT_WIDTH'(170265);
      7'b0000100: base = CNT_WIDTH'(151685);
      7'b0001000: base = CNT_WIDTH'(143172);
      7'b0010000: base = CNT_WIDTH'(127551);
      7'b0100000: base = CNT_WIDTH'(113636);
      7'b1000000: base = CNT_WIDTH'(101239);
      default:    base = '0;
    endcase
    case (code[1:0])
      2'b01:   return base >> 1;
      2'b10:   return base << 1;
      default: return base;
    endcase
  endfunction

  always_comb begin
    w_eff_code    = (bus.note_valid && bus.enable) ? bus.note_code : '0;
    w_eff_rest    = (w_eff_code[8:2] == '0);
    w_eff_invalid = !w_eff_rest && (w_eff_code[9] || !$onehot(w_eff_code[8:2]));
    w_eff_note    = !w_eff_rest && !w_eff_invalid;
    w_next_hp     = w_eff_note ? f_half_per(w_eff_code) : '0;
    w_change      = (w_eff_code != r_cur_code);
    w_toggle      = (r_cnt == r_half_per);
`ifdef TONE_SYNC_CHANGE_EN
    // Note-to-note changes wait for the toggle point; the newest effective code is the pending one.
    w_load        = w_change && (!(r_playing && w_eff_note) || w_toggle);
`else
    w_load        = w_change;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_code <= '0;
      r_half_per <= '0;
      r_cnt      <= CNT_WIDTH'(1);
      r_tone     <= 1'b0;
      r_playing  <= 1'b0;
      r_code_err <= 1'b0;
    end else begin
      if (w_load && w_eff_invalid)
        r_code_err <= 1'b1;
      if (w_load) begin
        r_cur_code <= w_eff_code;
        r_half_per <= w_next_hp;
        r_cnt      <= CNT_WIDTH'(1);
        r_tone     <= w_eff_note;
        r_playing  <= w_eff_note;
      end else if (r_playing) begin
        if (w_toggle) begin
          r_tone <= ~r_tone;
          r_cnt  <= CNT_WIDTH'(1);
        end else begin
          r_cnt  <= r_cnt + CNT_WIDTH'(1);
        end
      end else begin
        r_tone <= 1'b0;
        r_cnt  <= CNT_WIDTH'(1);
      end
    end
  end

  assign bus.tone_out = r_tone;
  assign bus.playing  = r_playing;
  assign bus.code_err = r_code_err;

endmodule

// File: doc/note_tone_generator.md
# note_tone_generator

Downstream consumer of the internal music memory read port: turns the stream of 10-bit note codes into a square-wave tone for the buzzer pin. It registers each new code, looks up its half-period in a fixed table, and runs a half-period counter that toggles `tone_out`. Rests, invalid codes and loss of `note_valid` silence the output.

## Interface
- `CNT_WIDTH`, 20: half-period counter width; must hold 382220.
- `clk`  in  1  system clock, 100 MHz; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  global play enable; low forces silence.
- `note_valid`  in  1  code valid this cycle; driven from the memory's `output_ready`.
- `note_code`  in  `DATA_WIDTH` (10)  note code; driven from the memory's `data_out`.
- `tone_out`  out  1  square wave to the buzzer.
- `playing`  out  1  high while a non-rest note is sounding.
- `code_err`  out  1  sticky: an invalid code was accepted.

## Operation
- Code format:
  - bit 9 reserved; must be 0.
  - bits [8:2] one-hot note: bit2 = C, bit3 = D, bit4 = E, bit5 = F, bit6 = G, bit7 = A, bit8 = B.
  - bits [1:0] octave: 00 or 11 = middle, 01 = high, 10 = low.
- Rest: bits [8:2] all zero; bits [9] and [1:0] are ignored.
- Invalid code: bit 9 set, or more than one bit of [8:2] set.
  - Treated as a rest.
  - Sets `code_err`, which stays set until `rst`.
- Middle-octave half-periods in clk cycles:
  - C 191110, D 170265, E 151685, F 143172, G 127551, A 113636, B 101239.
  - High octave = table >> 1 (truncate). Low octave = table << 1.
- Registers:
  - `cur_code`, 10 bits, reset 0.
  - `half_per`, `CNT_WIDTH` bits, reset 0.
  - `cnt`, `CNT_WIDTH` bits, reset 1.
- Effective code:
  - `note_code` when `note_valid` and `enable` are both high.
  - Otherwise the rest code 0.
- Capture: the effective code is compared with `cur_code` every cycle; a difference is a note change. An identical code, such as a repeated note across memory samples, causes no restart and no phase discontinuity.
- On a note change, in the next cycle:
  - `cur_code` and `half_per` load.
  - `cnt` loads 1.
  - `tone_out` goes to 1 for a note, 0 for a rest or invalid code.
- Running a note: `cnt` increments each cycle. When `cnt == half_per`, `tone_out` inverts and `cnt` reloads 1.
- Rest: `tone_out` and `playing` are 0 and `cnt` holds 1.
- `playing` equals "`cur_code` is a valid non-rest code".

## Timing
- Reset values: `tone_out` 0, `playing` 0, `code_err` 0, `cur_code` 0, `half_per` 0, `cnt` 1.
- Latency: a new code on `note_valid` in cycle N gives `tone_out` = 1 and `playing` = 1 in cycle N+1. The first falling edge comes `half_per` cycles later.
- Full period is exactly 2 × `half_per` cycles. Duty cycle is 50%.
- Dropping `note_valid` or `enable` in cycle N gives silence in cycle N+1.
- Mid-note `rst` overrides everything: outputs return to reset values in the next cycle. `code_err` is cleared.
- A note change arriving in the same cycle that `cnt == half_per` takes priority over the toggle (non-sync mode).
- Counter arithmetic is unsigned `CNT_WIDTH` bits. `cnt` never exceeds `half_per`, so there is no wrap-around.

## Configuration
- `TONE_SYNC_CHANGE_EN` defined: a note change while a note is sounding is deferred to the next toggle point (`cnt == half_per`).
  - At that point `cur_code` and `half_per` load and `tone_out` restarts at 1. This avoids clicks.
  - Changes from a rest, and changes to a rest, still apply after one cycle.
  - A pending code is overwritten by any newer effective code.
- Undefined: every note change applies after one cycle, as described in Operation.

## Test plan
- Reset, then `note_valid` = 1 and `note_code` = 0x004 (middle C) -> `tone_out` rises after 1 cycle. Falls 191110 cycles later. Period is 382220 cycles. `playing` = 1.
- Code 0x101 (high B) -> half-period 50619. Code 0x042 (low G) -> half-period 255102.
- Code 0x004 held across 4 consecutive 20833333-cycle samples -> no phase reset between samples. Then 0x000 -> `tone_out` = 0 and `playing` = 0 the next cycle.
- Code 0x00C (two notes set) or 0x204 (reserved bit set) -> silence, `code_err` = 1. A later valid code plays normally and `code_err` stays 1 until `rst`.
- Middle C playing, switch to middle G mid-half-period -> without the macro, restart next cycle with half-period 127551. With `TONE_SYNC_CHANGE_EN`, restart exactly at C's toggle point.
- `rst` asserted mid-note, and `enable` dropped mid-note -> all outputs reach reset or silent values in the next cycle.
